// File: rtl/reg_block_ctrl_pkg.sv
// reg_block_ctrl_pkg
//   Types shared by the register-block controller and whatever register
//   block it drives: the register-block operation code and the controller
//   command opcode. Also holds small helpers for address-range checks.
package reg_block_ctrl_pkg;

  typedef enum logic [1:0] {
    REG_OP_NONE  = 2'd0,
    REG_OP_READ  = 2'd1,
    REG_OP_WRITE = 2'd2
  } reg_op_t;

  typedef enum logic [2:0] {
    CMD_MOV     = 3'd0,
    CMD_LOAD    = 3'd1,
    CMD_STORE   = 3'd2,
    CMD_SWAP    = 3'd3,
    CMD_SAVE    = 3'd4,
    CMD_RESTORE = 3'd5
  } ctrl_cmd_t;

  // Commands that read or write through the source operand.
  function automatic logic uses_src(input ctrl_cmd_t c);
    return (c == CMD_MOV) || (c == CMD_STORE) || (c == CMD_SWAP);
  endfunction

  // Commands that read or write through the destination operand.
  function automatic logic uses_dst(input ctrl_cmd_t c);
    return (c == CMD_MOV) || (c == CMD_LOAD) || (c == CMD_SWAP);
  endfunction

  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/reg_block_ctrl.sv
// reg_block_ctrl
//   Sequences MOV / LOAD / STORE / SWAP / SAVE / RESTORE commands onto a
//   single-port register block (one read or write per cycle, plus whole-block
//   save/restore strobes). Commands are taken with a valid/ready handshake
//   in IDLE only; all register-block outputs decode from the registered state
//   and the fields captured at acceptance.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   cmd_valid/ready    command handshake (ready only in IDLE)
//   cmd, src/dst_addr  opcode and register operands
//   data_in            LOAD data
//   data_out/valid     STORE result, valid pulses for one cycle
//   err                one-cycle pulse after accepting an out-of-range address
//   reg_addr, reg_op,  register-block drive
//   reg_save,
//   reg_restore,
//   reg_bus_in
//   reg_bus_out        read data for reg_addr, same cycle as REG_OP_READ
module reg_block_ctrl
  import reg_block_ctrl_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  ctrl_cmd_t        cmd,
  input  logic [AW-1:0]    src_addr,
  input  logic [AW-1:0]    dst_addr,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             err,
  output logic [AW-1:0]    reg_addr,
  output reg_op_t          reg_op,
  output logic             reg_save,
  output logic             reg_restore,
  output logic [WIDTH-1:0] reg_bus_in,
  input  logic [WIDTH-1:0] reg_bus_out
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_B = 3'd4,
    ST_CTX  = 3'd5
  } state_t;

  state_t           r_state, w_next;
  ctrl_cmd_t        r_cmd;
  logic [AW-1:0]    r_src, r_dst;
  logic [WIDTH-1:0] r_data, r_tmp_a, r_tmp_b, r_data_out;
  logic             r_data_valid, r_err;
  logic             w_accept, w_bad;

  assign cmd_ready  = (r_state == ST_IDLE);
  assign w_accept   = cmd_ready && cmd_valid;
  // Only operands the opcode actually uses are range-checked.
  assign w_bad      = (uses_src(cmd) && !addr_in_range(32'(src_addr), 32'(DEPTH))) ||
                      (uses_dst(cmd) && !addr_in_range(32'(dst_addr), 32'(DEPTH)));
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign err        = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    reg_op      = REG_OP_NONE;
    reg_addr    = '0;
    reg_bus_in  = '0;
    reg_save    = 1'b0;
    reg_restore = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A rejected address is still accepted, but never leaves IDLE.
        if (w_accept && !w_bad) begin
          case (cmd)
            CMD_MOV, CMD_STORE, CMD_SWAP: w_next = ST_RD_A;
            CMD_LOAD:                     w_next = ST_WR_B;
            CMD_SAVE, CMD_RESTORE:        w_next = ST_CTX;
            default:                      w_next = ST_IDLE;
          endcase
        end
      end
      ST_RD_A: begin
        reg_addr = r_src;
        reg_op   = REG_OP_READ;
        if (r_cmd == CMD_SWAP)     w_next = ST_RD_B;
        else if (r_cmd == CMD_MOV) w_next = ST_WR_B;
        else                       w_next = ST_IDLE;
      end
      ST_RD_B: begin
        reg_addr = r_dst;
        reg_op   = REG_OP_READ;
        w_next   = ST_WR_A;
      end
      ST_WR_A: begin
        reg_addr   = r_src;
        reg_op     = REG_OP_WRITE;
        reg_bus_in = r_tmp_b;
        w_next     = ST_WR_B;
      end
      ST_WR_B: begin
        reg_addr   = r_dst;
        reg_op     = REG_OP_WRITE;
        reg_bus_in = (r_cmd == CMD_LOAD) ? r_data : r_tmp_a;
        w_next     = ST_IDLE;
      end
      ST_CTX: begin
        reg_save    = (r_cmd == CMD_SAVE);
        reg_restore = (r_cmd == CMD_RESTORE);
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd        <= CMD_MOV;
      r_src        <= '0;
      r_dst        <= '0;
      r_data       <= '0;
      r_tmp_a      <= '0;
      r_tmp_b      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // STORE's read lands in data_out; the pulse marks the first IDLE cycle.
      r_data_valid <= (r_state == ST_RD_A) && (r_cmd == CMD_STORE);
      r_err        <= w_accept && w_bad;
      if (w_accept) begin
        r_cmd  <= cmd;
        r_src  <= src_addr;
        r_dst  <= dst_addr;
        r_data <= data_in;
      end
      if (r_state == ST_RD_A) begin
        r_tmp_a <= reg_bus_out;
        if (r_cmd == CMD_STORE) r_data_out <= reg_bus_out;
      end
      if (r_state == ST_RD_B) r_tmp_b <= reg_bus_out;
    end
  end

endmodule

// File: tb/tb_reg_block_ctrl.sv
module tb_reg_block_ctrl;
  import reg_block_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // ---------------- instance A: DEPTH 4 ----------------
  logic      a_cmd_valid, a_cmd_ready, a_dv, a_err, a_save, a_rest;
  ctrl_cmd_t a_cmd;
  logic [1:0] a_src, a_dst, a_raddr;
  logic [7:0] a_din, a_dout, a_bin, a_bout;
  reg_op_t   a_op;
  logic [7:0] a_regs [4];
  logic [7:0] a_shadow [4];

  reg_block_ctrl #(.WIDTH(8), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd(a_cmd), .src_addr(a_src), .dst_addr(a_dst), .data_in(a_din),
    .data_out(a_dout), .data_valid(a_dv), .err(a_err), .reg_addr(a_raddr),
    .reg_op(a_op), .reg_save(a_save), .reg_restore(a_rest),
    .reg_bus_in(a_bin), .reg_bus_out(a_bout)
  );

  // Register block environment for A (not reset: survives controller reset).
  assign a_bout = a_regs[a_raddr];
  always @(posedge clk) begin
    if (a_op == REG_OP_WRITE) a_regs[a_raddr] <= a_bin;
    for (int i = 0; i < 4; i++) begin
      if (a_save) a_shadow[i] <= a_regs[i];
      if (a_rest) a_regs[i]   <= a_shadow[i];
    end
  end

  // ---------------- instance B: DEPTH 3 ----------------
  logic      b_cmd_valid, b_cmd_ready, b_dv, b_err, b_save, b_rest;
  ctrl_cmd_t b_cmd;
  logic [1:0] b_src, b_dst, b_raddr;
  logic [7:0] b_din, b_dout, b_bin, b_bout;
  reg_op_t   b_op;
  logic [7:0] b_regs [4];
  int         b_wr_cnt = 0;

  reg_block_ctrl #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd(b_cmd), .src_addr(b_src), .dst_addr(b_dst), .data_in(b_din),
    .data_out(b_dout), .data_valid(b_dv), .err(b_err), .reg_addr(b_raddr),
    .reg_op(b_op), .reg_save(b_save), .reg_restore(b_rest),
    .reg_bus_in(b_bin), .reg_bus_out(b_bout)
  );

  assign b_bout = b_regs[b_raddr];
  always @(posedge clk) if (b_op == REG_OP_WRITE) b_regs[b_raddr] <= b_bin;
  always @(negedge clk) if (b_op == REG_OP_WRITE) b_wr_cnt <= b_wr_cnt + 1;

  // ---------------- reference model ----------------
  // Architectural view: four registers, one saved snapshot, last STORE value.
  logic [7:0] m [4];
  logic [7:0] m_shadow [4];
  logic [7:0] m_last_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_r%0d", tag, i), 32'(a_regs[i]), 32'(m[i]));
  endtask

  // Issues one command on A starting at a negedge; returns at the negedge of
  // the first IDLE cycle so the next call is back-to-back.
  task automatic do_a(input ctrl_cmd_t c, input int s, input int d, input logic [7:0] dat,
                      input string tag);
    int busy, nsave, nrest, nwr, lim, exp_busy, exp_wr;
    logic [7:0] t;
    bit is_store;
    is_store = (c == CMD_STORE);
    exp_wr   = 0;
    case (c)
      CMD_MOV:     begin exp_busy = 2; exp_wr = 1; m[d] = m[s]; end
      CMD_LOAD:    begin exp_busy = 1; exp_wr = 1; m[d] = dat; end
      CMD_STORE:   begin exp_busy = 1; m_last_out = m[s]; end
      CMD_SWAP:    begin exp_busy = 4; exp_wr = 2; t = m[s]; m[s] = m[d]; m[d] = t; end
      CMD_SAVE:    begin exp_busy = 1; m_shadow = m; end
      default:     begin exp_busy = 1; m = m_shadow; end
    endcase
    lim = 0;
    while (!a_cmd_ready && lim < 20) begin @(negedge clk); lim++; end
    chk({tag, "_ready_in"}, 32'(a_cmd_ready), 32'd1);
    a_cmd = c; a_src = 2'(s); a_dst = 2'(d); a_din = dat; a_cmd_valid = 1'b1;
    @(negedge clk);
    busy = 0; nsave = 0; nrest = 0; nwr = 0;
    while (!a_cmd_ready && busy < 20) begin
      // Scrambled inputs and stray valids while busy must be ignored.
      a_cmd_valid = 1'($urandom);
      a_cmd = ctrl_cmd_t'(3'($urandom_range(0, 5)));
      a_src = 2'($urandom); a_dst = 2'($urandom); a_din = 8'($urandom);
      busy++;
      if (a_save) nsave++;
      if (a_rest) nrest++;
      if (a_op == REG_OP_WRITE) nwr++;
      if (a_save && a_rest) chk({tag, "_save_and_restore"}, 32'd1, 32'd0);
      @(negedge clk);
    end
    a_cmd_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    chk({tag, "_writes"}, 32'(nwr), 32'(exp_wr));
    chk({tag, "_save_cnt"}, 32'(nsave), 32'(c == CMD_SAVE));
    chk({tag, "_restore_cnt"}, 32'(nrest), 32'(c == CMD_RESTORE));
    chk({tag, "_dv"}, 32'(a_dv), 32'(is_store));
    chk({tag, "_dout"}, 32'(a_dout), 32'(m_last_out));
    chk({tag, "_err"}, 32'(a_err), 32'd0);
    chk({tag, "_idle_op"}, 32'(a_op), 32'(REG_OP_NONE));
    chk_regs(tag);
    if (is_store) begin
      @(negedge clk);
      chk({tag, "_dv_pulse"}, 32'(a_dv), 32'd0);
    end
  endtask

  // Single command on B; expects an err pulse (and no write) when exp_err.
  task automatic do_b(input ctrl_cmd_t c, input int s, input int d, input logic [7:0] dat,
                      input bit exp_err, input int exp_wr, input string tag);
    int wr0, lim;
    wr0 = b_wr_cnt;
    b_cmd = c; b_src = 2'(s); b_dst = 2'(d); b_din = dat; b_cmd_valid = 1'b1;
    @(negedge clk);
    b_cmd_valid = 1'b0;
    #1;
    chk({tag, "_err"}, 32'(b_err), 32'(exp_err));
    lim = 0;
    while (!b_cmd_ready && lim < 20) begin @(negedge clk); lim++; end
    @(negedge clk); #1;
    chk({tag, "_err_pulse"}, 32'(b_err), 32'd0);
    chk({tag, "_ready"}, 32'(b_cmd_ready), 32'd1);
    chk({tag, "_writes"}, 32'(b_wr_cnt - wr0), 32'(exp_wr));
  endtask

  initial begin
    rst = 1'b1;
    a_cmd_valid = 0; a_cmd = CMD_MOV; a_src = 0; a_dst = 0; a_din = 0;
    b_cmd_valid = 0; b_cmd = CMD_MOV; b_src = 0; b_dst = 0; b_din = 0;
    for (int i = 0; i < 4; i++) begin m[i] = 8'h00; m_shadow[i] = 8'h00; end
    m_last_out = 8'h00;
    #1;
    chk("rst_ready", 32'(a_cmd_ready), 32'd1);
    chk("rst_op", 32'(a_op), 32'(REG_OP_NONE));
    chk("rst_addr", 32'(a_raddr), 32'd0);
    chk("rst_bus_in", 32'(a_bin), 32'd0);
    chk("rst_dout", 32'(a_dout), 32'd0);
    chk("rst_dv", 32'(a_dv), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_save_restore", 32'({a_save, a_rest}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) do_a(CMD_LOAD, 0, i, 8'h00, "init");

    // LOAD then STORE round trip
    do_a(CMD_LOAD, 0, 2, 8'h5A, "load2");
    do_a(CMD_STORE, 2, 0, 8'h00, "store2");
    chk("store2_value", 32'(a_dout), 32'h5A);

    // SWAP
    do_a(CMD_LOAD, 0, 1, 8'h11, "load1");
    do_a(CMD_LOAD, 0, 3, 8'h33, "load3");
    do_a(CMD_SWAP, 1, 3, 8'h00, "swap13");
    chk("swap_r1", 32'(a_regs[1]), 32'h33);
    chk("swap_r3", 32'(a_regs[3]), 32'h11);

    // MOV, including src == dst
    do_a(CMD_LOAD, 0, 0, 8'hA5, "load0");
    do_a(CMD_MOV, 0, 0, 8'h00, "mov00");
    chk("mov00_r0", 32'(a_regs[0]), 32'hA5);
    do_a(CMD_MOV, 0, 1, 8'h00, "mov01");
    chk("mov01_r1", 32'(a_regs[1]), 32'hA5);
    do_a(CMD_SWAP, 2, 2, 8'h00, "swap22");

    // SAVE / LOAD / RESTORE
    do_a(CMD_SAVE, 0, 0, 8'h00, "save");
    do_a(CMD_LOAD, 0, 0, 8'hFF, "loadff");
    do_a(CMD_RESTORE, 0, 0, 8'h00, "restore");
    chk("restore_r0", 32'(a_regs[0]), 32'hA5);

    // Random back-to-back traffic
    for (int k = 0; k < 40; k++)
      do_a(ctrl_cmd_t'(3'($urandom_range(0, 5))), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), 8'($urandom), $sformatf("rnd%0d", k));

    // Reset during RD_B of a SWAP: aborted, no write, outputs idle at once
    do_a(CMD_LOAD, 0, 1, 8'h1C, "pre_r1");
    do_a(CMD_LOAD, 0, 2, 8'h2C, "pre_r2");
    a_cmd = CMD_SWAP; a_src = 2'd1; a_dst = 2'd2; a_cmd_valid = 1'b1;
    @(negedge clk);                   // in RD_A
    a_cmd_valid = 1'b0;
    @(negedge clk);                   // in RD_B
    chk("rdb_op", 32'(a_op), 32'(REG_OP_READ));
    chk("rdb_addr", 32'(a_raddr), 32'd2);
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(a_cmd_ready), 32'd1);
    chk("midrst_op", 32'(a_op), 32'(REG_OP_NONE));
    chk("midrst_addr", 32'(a_raddr), 32'd0);
    chk("midrst_bus_in", 32'(a_bin), 32'd0);
    chk("midrst_dout", 32'(a_dout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_last_out = 8'h00;
    repeat (4) @(negedge clk);
    chk("midrst_op_after", 32'(a_op), 32'(REG_OP_NONE));
    chk_regs("midrst");
    do_a(CMD_STORE, 1, 0, 8'h00, "post_rst_store");

    // DEPTH 3 instance: out-of-range addresses
    do_b(CMD_LOAD, 0, 2, 8'h77, 1'b0, 1, "b_load2");
    chk("b_r2", 32'(b_regs[2]), 32'h77);
    do_b(CMD_LOAD, 0, 3, 8'h99, 1'b1, 0, "b_load3");
    do_b(CMD_MOV, 3, 0, 8'h00, 1'b1, 0, "b_mov30");
    do_b(CMD_STORE, 3, 0, 8'h00, 1'b1, 0, "b_store3");
    chk("b_store3_dv", 32'(b_dv), 32'd0);
    do_b(CMD_SAVE, 3, 3, 8'h00, 1'b0, 0, "b_save_any_addr");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_block_ctrl.md
REG_BLOCK_CTRL -- requirements
Module: reg_block_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of registers in the controlled register block (AW = $clog2(DEPTH)).
REQ-003 SHALL have ports clk (input, 1): single clock, all state updates on rising edge.
REQ-004 SHALL have port rst (input, 1): asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid (input, 1): command request.
REQ-006 SHALL have port cmd_ready (output, 1): controller can accept a command.
REQ-007 SHALL have port cmd (input, ctrl_cmd_t): opcode, one of CMD_MOV, CMD_LOAD, CMD_STORE, CMD_SWAP, CMD_SAVE, CMD_RESTORE.
REQ-008 SHALL have ports src_addr and dst_addr (input, AW each): register operands.
REQ-009 SHALL have port data_in (input, WIDTH): LOAD data.
REQ-010 SHALL have port data_out (output, WIDTH): STORE result.
REQ-011 SHALL have port data_valid (output, 1): one-cycle pulse qualifying data_out.
REQ-012 SHALL have port err (output, 1): one-cycle pulse on an out-of-range address.
REQ-013 SHALL have ports reg_addr (output, AW), reg_op (output, reg_op_t), reg_save (output, 1), reg_restore (output, 1), reg_bus_in (output, WIDTH): drive the register block.
REQ-014 SHALL have port reg_bus_out (input, WIDTH): read data from the addressed register, valid in the same cycle as reg_op = REG_OP_READ.

Function
REQ-015 Command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1; cmd, src_addr, dst_addr, data_in captured then, later changes ignored.
REQ-016 cmd_ready SHALL be 1 only in state IDLE; cmd_valid while busy SHALL have no effect.
REQ-017 States: IDLE, RD_A, RD_B, WR_A, WR_B, CTX; register-block outputs SHALL be decoded from the registered state and captured fields only.
REQ-018 MOV: IDLE -> RD_A (reg_addr=src, REG_OP_READ, tmp_a <= reg_bus_out) -> WR_B (reg_addr=dst, REG_OP_WRITE, reg_bus_in=tmp_a) -> IDLE; 2 busy cycles.
REQ-019 LOAD: IDLE -> WR_B (reg_addr=dst, REG_OP_WRITE, reg_bus_in=captured data_in) -> IDLE; 1 busy cycle.
REQ-020 STORE: IDLE -> RD_A (reg_addr=src, REG_OP_READ) -> IDLE; data_out <= reg_bus_out and data_valid=1 in the first IDLE cycle only; data_out holds until the next STORE.
REQ-021 SWAP: RD_A (src -> tmp_a) -> RD_B (dst -> tmp_b) -> WR_A (src <= tmp_b) -> WR_B (dst <= tmp_a) -> IDLE; 4 busy cycles.
REQ-022 SAVE/RESTORE: IDLE -> CTX for one cycle with reg_save (resp. reg_restore) = 1, reg_op = REG_OP_NONE -> IDLE.
REQ-023 reg_save and reg_restore SHALL never be 1 together, and SHALL be 0 outside CTX.
REQ-024 reg_op SHALL be REG_OP_NONE in IDLE and CTX; reg_addr SHALL be 0 in IDLE.
REQ-025 MOV/SWAP with src_addr == dst_addr SHALL run the full sequence and leave the register value unchanged.
REQ-026 Any used address >= DEPTH SHALL cause acceptance, no register op, err=1 for one cycle after acceptance, and a return to IDLE.
REQ-027 Back-to-back commands SHALL be supported: a new command can be accepted in the first IDLE cycle after completion.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, cmd_ready=1, reg_op=REG_OP_NONE, reg_save=0, reg_restore=0, reg_addr=0, reg_bus_in=0, data_out=0, data_valid=0, err=0, tmp_a=tmp_b=0.
REQ-029 Reset mid-sequence SHALL abort it with no further register writes; partial SWAP results are not rolled back.

Structure
REQ-030 ctrl_cmd_t SHALL be added to the shared package alongside reg_op_t (REG_OP_NONE, REG_OP_READ, REG_OP_WRITE); the state enum SHALL be local.
REQ-031 The module SHALL be flat with no sub-modules; the integration top SHALL connect it to one register block instance.

Verification
REQ-032 LOAD dst=2 data 0x5A, then STORE src=2 -> data_valid pulse with data_out=0x5A, 1 busy cycle each.
REQ-033 r1=0x11, r3=0x33, SWAP src=1 dst=3 -> r1=0x33, r3=0x11, cmd_ready low for exactly 4 cycles.
REQ-034 MOV src=0 (0xA5) dst=0 -> r0 stays 0xA5; MOV src=0 dst=1 -> r1=0xA5 after 2 cycles.
REQ-035 SAVE, then LOAD r0=0xFF, then RESTORE -> single-cycle reg_save/reg_restore pulses, r0 back to prior value.
REQ-036 DEPTH=3, LOAD dst=3 -> err pulse, no REG_OP_WRITE observed; rst asserted during RD_B of a SWAP -> outputs idle at once, no write.
